// File: rtl/cpu_ctrl_seq.sv
// Instruction sequencer for the basic-computer CPU: owns PC/IR/EA and walks
// fetch/decode/indirect/resolve/execute against a req/ack memory port.
module cpu_ctrl_seq #(
    parameter int DWIDTH   = 16,
    parameter int AWIDTH   = 12,
    parameter int RESET_PC = 0,
    parameter int INT_VEC  = 0,
    localparam int OPW     = DWIDTH - 1 - AWIDTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_irq,
    input  logic              i_ien,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [AWIDTH-1:0] o_mem_addr,
    output logic [DWIDTH-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DWIDTH-1:0] i_mem_rdata,
    output logic              o_exec,
    output logic [OPW-1:0]    o_opcode,
    output logic              o_ind,
    output logic              o_reg_ref,
    output logic              o_io_ref,
    output logic [AWIDTH-1:0] o_ea,
    output logic [DWIDTH-1:0] o_ir,
    output logic [AWIDTH-1:0] o_pc,
    input  logic              i_ex_done,
    input  logic              i_skip,
    input  logic              i_pc_load,
    input  logic [AWIDTH-1:0] i_pc_value,
    output logic              o_busy,
    output logic              o_halt,
    output logic              o_int_ack
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_INDIRECT, S_RESOLVE, S_EXEC, S_INTR, S_HALT
    } state_t;

    localparam logic [AWIDTH-1:0] RESET_PC_A = AWIDTH'(RESET_PC);
    localparam logic [AWIDTH-1:0] INT_VEC_A  = AWIDTH'(INT_VEC);
    localparam logic [OPW-1:0]    OP_BUN     = OPW'(4);

    state_t              state, next_state, dispatch;
    logic [AWIDTH-1:0]   pc, ea;
    logic [DWIDTH-1:0]   ir;
    logic                mem_req_q, exec_q, int_ack_q;
    logic                xfer;
    logic [OPW-1:0]      opcode;
    logic                ind, reg_ref, io_ref;

    assign opcode  = ir[DWIDTH-2:AWIDTH];
    assign ind     = ir[DWIDTH-1];
    assign reg_ref = (&opcode) & ~ind;
    assign io_ref  = (&opcode) & ind;
    assign xfer    = mem_req_q & i_mem_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        dispatch   = (i_irq && i_ien) ? S_INTR : S_FETCH;
        next_state = state;
        case (state)
            S_IDLE, S_HALT: if (i_start) next_state = dispatch;
            S_FETCH:        if (xfer) next_state = S_DECODE;
            S_DECODE: begin
                if (reg_ref && ir[0])  next_state = S_HALT;
                else if (&opcode)      next_state = S_EXEC;
                else if (ind)          next_state = S_INDIRECT;
                else                   next_state = S_RESOLVE;
            end
            S_INDIRECT:     if (xfer) next_state = S_RESOLVE;
            S_RESOLVE:      next_state = (opcode == OP_BUN) ? dispatch : S_EXEC;
            S_EXEC:         if (i_ex_done) next_state = dispatch;
            S_INTR:         if (xfer) next_state = S_FETCH;
            default:        next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC_A;
            ir <= '0;
            ea <= '0;
        end else begin
            case (state)
                S_FETCH: if (xfer) begin
                    ir <= i_mem_rdata;
                    pc <= pc + AWIDTH'(1);
                end
                S_DECODE:   ea <= ir[AWIDTH-1:0];
                S_INDIRECT: if (xfer) ea <= i_mem_rdata[AWIDTH-1:0];
                S_RESOLVE:  if (opcode == OP_BUN) pc <= ea;
                S_EXEC: if (i_ex_done) begin
                    if (i_pc_load)   pc <= i_pc_value;
                    else if (i_skip) pc <= pc + AWIDTH'(1);
                end
                S_INTR:     if (xfer) pc <= INT_VEC_A + AWIDTH'(1);
                default: ;
            endcase
        end
    end

    // Request is registered off the next state; clearing it on a completed
    // transfer forces one idle cycle before any back-to-back request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req_q <= 1'b0;
            exec_q    <= 1'b0;
            int_ack_q <= 1'b0;
        end else begin
            mem_req_q <= (next_state inside {S_FETCH, S_INDIRECT, S_INTR}) && !xfer;
            exec_q    <= (next_state == S_EXEC) && (state != S_EXEC);
            int_ack_q <= (state == S_INTR) && xfer;
        end
    end

    always_comb begin
        o_busy      = !(state inside {S_IDLE, S_HALT});
        o_halt      = (state == S_HALT);
        o_mem_we    = (state == S_INTR);
        o_mem_wdata = {{(DWIDTH-AWIDTH){1'b0}}, pc};
        o_mem_addr  = pc;
        if (state == S_INDIRECT) o_mem_addr = ea;
        else if (state == S_INTR) o_mem_addr = INT_VEC_A;
    end

    assign o_mem_req = mem_req_q;
    assign o_exec    = exec_q;
    assign o_int_ack = int_ack_q;
    assign o_opcode  = opcode;
    assign o_ind     = ind;
    assign o_reg_ref = reg_ref;
    assign o_io_ref  = io_ref;
    assign o_ea      = ea;
    assign o_ir      = ir;
    assign o_pc      = pc;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Bench for cpu_ctrl_seq: vector table, hand sequences for multi-cycle corners,
// and a random program run checked against an instruction-level model.
module tb_cpu_ctrl_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_start = 1'b0, i_irq = 1'b0, i_ien = 1'b0;
    logic        o_mem_req, o_mem_we;
    logic [11:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic        i_mem_ack = 1'b0;
    logic [15:0] i_mem_rdata = '0;
    logic        o_exec;
    logic [2:0]  o_opcode;
    logic        o_ind, o_reg_ref, o_io_ref;
    logic [11:0] o_ea, o_pc;
    logic [15:0] o_ir;
    logic        i_ex_done = 1'b0, i_skip = 1'b0, i_pc_load = 1'b0;
    logic [11:0] i_pc_value = '0;
    logic        o_busy, o_halt, o_int_ack;

    cpu_ctrl_seq #(.DWIDTH(16), .AWIDTH(12), .RESET_PC(0), .INT_VEC(0)) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_irq(i_irq), .i_ien(i_ien),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_exec(o_exec), .o_opcode(o_opcode), .o_ind(o_ind), .o_reg_ref(o_reg_ref),
        .o_io_ref(o_io_ref), .o_ea(o_ea), .o_ir(o_ir), .o_pc(o_pc),
        .i_ex_done(i_ex_done), .i_skip(i_skip), .i_pc_load(i_pc_load),
        .i_pc_value(i_pc_value), .o_busy(o_busy), .o_halt(o_halt), .o_int_ack(o_int_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        skip;
        logic        load;
        logic [11:0] val;
        logic        irq;
    } resp_t;

    // kind: 0 read, 1 write, 2 exec, 3 halt
    typedef struct {
        int kind;
        int a;
        int b;
        int c;
        int d;
    } ev_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] aux;
        logic        skip;
        logic        load;
        logic [11:0] val;
        int          exd;
        int          x_exec;
        int          x_op;
        int          x_ea;
        int          x_pc;
        int          x_flags;
        int          x_reads;
        int          x_last;
    } vec_t;

    logic [15:0] mem [4096];
    logic [15:0] mm  [4096];
    resp_t       resp [1024];
    ev_t         dut_ev[$];
    ev_t         exp_ev[$];
    vec_t        vt [10];

    int errors = 0, checks = 0;
    int ack_delay_cfg = 0, ex_delay_cfg = 0;
    bit auto_start = 0, force_ack = 0;
    bit waiting = 0, xfer_pending = 0, in_exec = 0, halt_prev = 0;
    int wait_cnt = 0, ex_cnt = 0, req_cycles = 0, int_ack_cnt = 0, dp_idx = 0;
    logic [11:0] cap_addr = '0;
    logic        cap_we = 1'b0;
    logic [15:0] cap_wdata = '0;
    resp_t       cur_r;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_ev(int k, int a, int b, int c, int d);
        ev_t e;
        e.kind = k; e.a = a; e.b = b; e.c = c; e.d = d;
        dut_ev.push_back(e);
    endfunction

    function automatic ev_t get_ev(int i);
        ev_t e;
        e = '{kind: -1, a: -1, b: -1, c: -1, d: -1};
        if (i < dut_ev.size()) e = dut_ev[i];
        return e;
    endfunction

    // One clock: observe outputs after the edge, then play memory and datapath.
    task automatic tick();
        @(posedge clk); #1;
        if (xfer_pending) begin
            push_ev(cap_we ? 1 : 0, int'(cap_addr), cap_we ? int'(cap_wdata) : 0, 0, 0);
            if (cap_we) mem[cap_addr] = cap_wdata;
            waiting = 0;
            chk("req_gap", int'(o_mem_req), 0);
        end
        if (i_ex_done) begin
            i_ex_done = 0; i_skip = 0; i_pc_load = 0;
        end
        if (o_int_ack) int_ack_cnt++;
        if (o_halt && !halt_prev) push_ev(3, int'(o_pc), 0, 0, 0);
        halt_prev = o_halt;
        i_start = auto_start && o_halt;
        if (o_exec) begin
            push_ev(2, int'(o_opcode), int'(o_ea), int'(o_pc), int'({o_reg_ref, o_io_ref, o_ind}));
            cur_r  = resp[dp_idx % 1024];
            dp_idx++;
            i_irq  = cur_r.irq;
            ex_cnt = (ex_delay_cfg < 0) ? int'($urandom_range(0, 2)) : ex_delay_cfg;
            in_exec = 1;
        end
        if (in_exec) begin
            if (ex_cnt == 0) begin
                i_ex_done = 1; i_skip = cur_r.skip; i_pc_load = cur_r.load;
                i_pc_value = cur_r.val; in_exec = 0;
            end else ex_cnt--;
        end
        if (o_mem_req) begin
            req_cycles++;
            if (!waiting) begin
                waiting = 1; cap_addr = o_mem_addr; cap_we = o_mem_we; cap_wdata = o_mem_wdata;
                wait_cnt = (ack_delay_cfg < 0) ? int'($urandom_range(0, 2)) : ack_delay_cfg;
            end else begin
                chk("req_addr_stable", int'(o_mem_addr), int'(cap_addr));
                chk("req_we_stable", int'(o_mem_we), int'(cap_we));
            end
            if (wait_cnt == 0) begin
                i_mem_ack = 1; i_mem_rdata = mem[o_mem_addr];
            end else begin
                i_mem_ack = 0; wait_cnt--;
            end
        end else begin
            waiting = 0;
            i_mem_ack = force_ack;
        end
        xfer_pending = o_mem_req && i_mem_ack;
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset_n = 0; i_start = 0; i_irq = 0; i_ien = 0; i_mem_ack = 0;
        i_ex_done = 0; i_skip = 0; i_pc_load = 0; force_ack = 0; auto_start = 0;
        waiting = 0; xfer_pending = 0; in_exec = 0; halt_prev = 0; dp_idx = 0;
        req_cycles = 0; int_ack_cnt = 0;
        dut_ev.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic fill_mem(logic [15:0] w);
        for (int i = 0; i < 4096; i++) mem[i] = w;
    endtask

    task automatic clear_resp();
        for (int i = 0; i < 1024; i++) resp[i] = '{skip: 0, load: 0, val: '0, irq: 0};
    endtask

    // Instruction-level model: one loop iteration per dispatched instruction.
    task automatic run_model(int n);
        int pc, irq, ri, ir, op, ind, ea, fl;
        ev_t e;
        resp_t r;
        pc = 0; irq = 0; ri = 0;
        exp_ev.delete();
        while (exp_ev.size() < n) begin
            if (irq != 0) begin
                e = '{kind: 1, a: 0, b: pc, c: 0, d: 0}; exp_ev.push_back(e);
                mm[0] = 16'(pc);
                pc = 1;
            end
            e = '{kind: 0, a: pc, b: 0, c: 0, d: 0}; exp_ev.push_back(e);
            ir  = int'(mm[pc]);
            pc  = (pc + 1) % 4096;
            op  = (ir >> 12) & 7;
            ind = (ir >> 15) & 1;
            ea  = ir & 12'hFFF;
            if (op == 7 && ind == 0 && (ir & 1) == 1) begin
                e = '{kind: 3, a: pc, b: 0, c: 0, d: 0}; exp_ev.push_back(e);
                continue;
            end
            if (op != 7) begin
                if (ind != 0) begin
                    e = '{kind: 0, a: ea, b: 0, c: 0, d: 0}; exp_ev.push_back(e);
                    ea = int'(mm[ea]) & 12'hFFF;
                end
                if (op == 4) begin
                    pc = ea;
                    continue;
                end
            end
            fl = ((op == 7 && ind == 0) ? 4 : 0) + ((op == 7 && ind == 1) ? 2 : 0) + ind;
            e = '{kind: 2, a: op, b: ea, c: pc, d: fl}; exp_ev.push_back(e);
            r = resp[ri % 1024];
            ri++;
            if (r.load) pc = int'(r.val);
            else if (r.skip) pc = (pc + 1) % 4096;
            irq = int'(r.irq);
        end
    endtask

    initial begin
        ev_t e;
        int reads, last, execs, rc, ok;

        //            instr     aux       sk ld val    exd ex op ea      pc flg rd last
        vt[0] = '{16'h2005, 16'h7001, 0, 0, 12'h000, 0, 1, 2, 12'h005, 1, 0, 2, 12'h001};
        vt[1] = '{16'hC010, 16'h0123, 0, 0, 12'h000, 0, 0, 0, 0,       0, 0, 3, 12'h123};
        vt[2] = '{16'h7001, 16'h7001, 0, 0, 12'h000, 0, 0, 0, 0,       0, 0, 1, 12'h000};
        vt[3] = '{16'h2005, 16'h7001, 1, 0, 12'h000, 2, 1, 2, 12'h005, 1, 0, 2, 12'h002};
        vt[4] = '{16'h2005, 16'h7001, 1, 1, 12'h02A, 1, 1, 2, 12'h005, 1, 0, 2, 12'h02A};
        vt[5] = '{16'h7020, 16'h7001, 0, 0, 12'h000, 0, 1, 7, 12'h020, 1, 4, 2, 12'h001};
        vt[6] = '{16'hF400, 16'h7001, 0, 0, 12'h000, 1, 1, 7, 12'h400, 1, 3, 2, 12'h001};
        vt[7] = '{16'hA010, 16'h0321, 0, 0, 12'h000, 0, 1, 2, 12'h321, 1, 1, 3, 12'h001};
        vt[8] = '{16'h4033, 16'h7001, 0, 0, 12'h000, 0, 0, 0, 0,       0, 0, 2, 12'h033};
        vt[9] = '{16'hB0FF, 16'hFABC, 0, 0, 12'h000, 2, 1, 3, 12'hABC, 1, 1, 3, 12'h001};

        // Reset state
        clear_resp();
        fill_mem(16'h7001);
        do_reset();
        chk("rst_req", int'(o_mem_req), 0);
        chk("rst_exec", int'(o_exec), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_halt", int'(o_halt), 0);
        chk("rst_int_ack", int'(o_int_ack), 0);
        chk("rst_pc", int'(o_pc), 0);
        chk("rst_ir", int'(o_ir), 0);
        chk("rst_ea", int'(o_ea), 0);

        // Single-instruction vectors
        for (int v = 0; v < 10; v++) begin
            fill_mem(16'h7001);
            clear_resp();
            mem[0] = vt[v].instr;
            mem[vt[v].instr[11:0]] = vt[v].aux;
            resp[0] = '{skip: vt[v].skip, load: vt[v].load, val: vt[v].val, irq: 0};
            ex_delay_cfg  = vt[v].exd;
            ack_delay_cfg = v % 3;
            do_reset();
            i_start = 1;
            run(40);
            reads = 0; last = -1; execs = 0;
            foreach (dut_ev[i]) begin
                if (dut_ev[i].kind == 3) break;
                if (dut_ev[i].kind == 0) begin reads++; last = dut_ev[i].a; end
                if (dut_ev[i].kind == 2) begin
                    execs++;
                    if (execs == 1) e = dut_ev[i];
                end
            end
            chk($sformatf("v%0d_execs", v), execs, vt[v].x_exec);
            chk($sformatf("v%0d_reads", v), reads, vt[v].x_reads);
            chk($sformatf("v%0d_next_fetch", v), last, vt[v].x_last);
            chk($sformatf("v%0d_halted", v), int'(o_halt), 1);
            if (vt[v].x_exec != 0 && execs != 0) begin
                chk($sformatf("v%0d_opcode", v), e.a, vt[v].x_op);
                chk($sformatf("v%0d_ea", v), e.b, vt[v].x_ea);
                chk($sformatf("v%0d_pc", v), e.c, vt[v].x_pc);
                chk($sformatf("v%0d_flags", v), e.d, vt[v].x_flags);
            end
        end

        // Halt, ignore stray ex_done, resume at PC=1
        fill_mem(16'h7001); clear_resp();
        ack_delay_cfg = 0; ex_delay_cfg = 0;
        do_reset();
        i_start = 1;
        run(10);
        chk("halt_state", int'(o_halt), 1);
        chk("halt_busy", int'(o_busy), 0);
        rc = req_cycles;
        i_ex_done = 1; i_pc_load = 1; i_pc_value = 12'h055;
        run(5);
        chk("halt_no_req", req_cycles, rc);
        chk("halt_ex_done_ignored", int'(o_pc), 1);
        i_start = 1;
        run(10);
        e = get_ev(2);
        chk("resume_kind", e.kind, 0);
        chk("resume_addr", e.a, 1);

        // Interrupt taken after EXEC at PC=7
        fill_mem(16'h7001); clear_resp();
        mem[0] = 16'h4006; mem[6] = 16'h2005;
        resp[0] = '{skip: 0, load: 0, val: '0, irq: 1};
        ex_delay_cfg = 1;
        do_reset();
        i_ien = 1;
        i_start = 1;
        run(40);
        chk("irq_exec_pc", get_ev(2).c, 7);
        chk("irq_wr_kind", get_ev(3).kind, 1);
        chk("irq_wr_addr", get_ev(3).a, 0);
        chk("irq_wr_data", get_ev(3).b, 16'h0007);
        chk("irq_next_fetch", get_ev(4).a, 1);
        chk("irq_int_ack_pulses", int_ack_cnt, 1);
        chk("irq_halt_ignored_req", int'(o_mem_req), 0);

        // PC wrap from 0xFFF
        fill_mem(16'h7001); clear_resp();
        mem[0] = 16'h4FFF; mem[12'hFFF] = 16'h2005;
        ex_delay_cfg = 0;
        do_reset();
        i_start = 1;
        run(30);
        chk("wrap_exec_kind", get_ev(2).kind, 2);
        chk("wrap_exec_pc", get_ev(2).c, 0);
        chk("wrap_next_fetch", get_ev(3).a, 0);

        // Ack delayed three cycles
        fill_mem(16'h7001); clear_resp();
        mem[0] = 16'h2005;
        ack_delay_cfg = 3;
        do_reset();
        i_start = 1;
        run(40);
        chk("slow_req_cycles", req_cycles, 8);
        chk("slow_next_fetch", get_ev(2).a, 1);

        // Reset during a pending read
        fill_mem(16'h7001); clear_resp();
        mem[0] = 16'h4123;
        ack_delay_cfg = 0;
        do_reset();
        i_start = 1;
        tick();
        ack_delay_cfg = 20;
        run(7);
        chk("pend_req", int'(o_mem_req), 1);
        chk("pend_addr", int'(o_mem_addr), 12'h123);
        #2 reset_n = 0;
        #1;
        chk("arst_req", int'(o_mem_req), 0);
        chk("arst_busy", int'(o_busy), 0);
        chk("arst_pc", int'(o_pc), 0);
        chk("arst_ir", int'(o_ir), 0);
        @(negedge clk);
        reset_n = 1;
        waiting = 0; xfer_pending = 0;
        force_ack = 1;
        rc = req_cycles;
        run(4);
        force_ack = 0;
        chk("arst_late_ack_req", req_cycles, rc);
        chk("arst_late_ack_busy", int'(o_busy), 0);

        // Random program against the instruction-level model
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 16'($urandom);
            mm[i]  = mem[i];
        end
        for (int i = 0; i < 1024; i++)
            resp[i] = '{skip: ($urandom_range(0, 3) == 0), load: ($urandom_range(0, 7) == 0),
                        val: 12'($urandom), irq: ($urandom_range(0, 5) == 0)};
        ack_delay_cfg = -1; ex_delay_cfg = -1;
        do_reset();
        i_ien = 1;
        auto_start = 1;
        i_start = 1;
        run(4000);
        chk("rand_progress", int'(dut_ev.size() > 100), 1);
        run_model(dut_ev.size());
        foreach (dut_ev[i]) begin
            ok = (dut_ev[i].kind == exp_ev[i].kind) && (dut_ev[i].a == exp_ev[i].a) &&
                 (dut_ev[i].b == exp_ev[i].b) && (dut_ev[i].c == exp_ev[i].c) &&
                 (dut_ev[i].d == exp_ev[i].d);
            checks++;
            if (ok == 0) begin
                errors++;
                $display("FAIL rand_ev[%0d]: got kind=%0d a=0x%0h b=0x%0h c=0x%0h d=%0d, expected kind=%0d a=0x%0h b=0x%0h c=0x%0h d=%0d",
                         i, dut_ev[i].kind, dut_ev[i].a, dut_ev[i].b, dut_ev[i].c, dut_ev[i].d,
                         exp_ev[i].kind, exp_ev[i].a, exp_ev[i].b, exp_ev[i].c, exp_ev[i].d);
                break;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
Parametrised instruction sequencer for the basic-computer CPU. It is the successor to the fixed 16-bit decode-only control unit.
- Owns PC, IR and effective-address (EA) registers.
- Runs a registered fetch/decode/indirect/execute FSM against a req/ack memory port.
- Handles BUN internally and hands all other instructions to the datapath via an exec/done handshake.
- Adds halt, skip/PC-load and a vectored interrupt. The control unit did not have these.

Parameters:
DWIDTH, 16, instruction/data word width
AWIDTH, 12, address width; opcode width OPW = DWIDTH-1-AWIDTH (must be >=2)
RESET_PC, 0, PC value after reset
INT_VEC, 0, interrupt save address; execution resumes at INT_VEC+1

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
i_start  in  1  leave IDLE/HALT and begin fetching
i_irq  in  1  interrupt request, level
i_ien  in  1  interrupt enable from datapath
o_mem_req  out  1  memory request, held until ack
o_mem_we  out  1  1=write, 0=read; valid with req
o_mem_addr  out  AWIDTH  request address
o_mem_wdata  out  DWIDTH  write data (PC zero-extended)
i_mem_ack  in  1  request accepted/complete; read data valid same cycle
i_mem_rdata  in  DWIDTH  read data
o_exec  out  1  one-cycle pulse on EXEC entry
o_opcode  out  OPW  ir[DWIDTH-2:AWIDTH]
o_ind  out  1  ir[DWIDTH-1]
o_reg_ref  out  1  opcode all-ones and I=0
o_io_ref  out  1  opcode all-ones and I=1
o_ea  out  AWIDTH  effective address
o_ir  out  DWIDTH  instruction register
o_pc  out  AWIDTH  program counter
i_ex_done  in  1  datapath finished instruction
i_skip  in  1  sampled with i_ex_done: PC+=1
i_pc_load  in  1  sampled with i_ex_done: PC<=i_pc_value (priority over skip)
i_pc_value  in  AWIDTH  new PC
o_busy  out  1  state not IDLE/HALT
o_halt  out  1  state==HALT
o_int_ack  out  1  one-cycle pulse when interrupt save completes

Behaviour:
- Reset (async): state=IDLE, PC=RESET_PC, IR=0, EA=0. Outputs o_mem_req, o_exec, o_int_ack, o_busy and o_halt are all 0.
- Reset mid-transaction drops o_mem_req immediately. Any later i_mem_ack is ignored.
- All outputs are registered or decoded from registers only. There are no combinational paths from inputs to outputs.
- DISPATCH rule: go to INTR if i_irq && i_ien, else FETCH. It is evaluated in the cycle the prior state exits.
- States:
  - IDLE: when i_start=1, apply DISPATCH.
  - FETCH: read at PC. On ack: IR<=rdata, PC<=PC+1 (mod 2^AWIDTH), go to DECODE.
  - DECODE (1 cycle): EA<=ir[AWIDTH-1:0].
    - Reg-ref with ir[0]=1 (HLT): go to HALT.
    - Other reg-ref or io-ref: go to EXEC.
    - I=1: go to INDIRECT.
    - Otherwise: go to RESOLVE.
  - INDIRECT: read at EA. On ack: EA<=rdata[AWIDTH-1:0], go to RESOLVE.
  - RESOLVE (1 cycle): if opcode==4 (BUN), PC<=EA and apply DISPATCH. Otherwise go to EXEC.
  - EXEC: o_exec=1 in the first cycle only. Hold until i_ex_done=1, then:
    - i_pc_load=1: PC<=i_pc_value.
    - else i_skip=1: PC<=PC+1.
    - Then apply DISPATCH.
    - i_ex_done is allowed in the o_exec cycle (1-cycle instruction).
  - INTR: write addr=INT_VEC, data=PC. On ack: PC<=INT_VEC+1, o_int_ack=1 for one cycle, go to FETCH (never re-dispatch).
  - HALT: when i_start=1, apply DISPATCH. i_irq is ignored while halted.
- Memory handshake:
  - req rises on state entry. addr, we and wdata stay stable while req=1.
  - The transfer completes in the cycle req&&ack.
  - req is 0 in the following cycle, even if the next state issues a new request (minimum one idle cycle between requests).
  - i_mem_ack while req=0 is ignored.
- o_opcode, o_ind, o_reg_ref and o_io_ref decode the held IR. They are valid from DECODE until the next IR load.
- i_ex_done outside EXEC is ignored.

Test Plan:
- Reset, i_start, mem[0]=16'h2005 (LDA 5, direct) -> read addr 0, DECODE, EXEC with o_opcode=2, o_ea=5, o_pc=1. Assert i_ex_done -> fetch at addr 1.
- mem[0]=16'hC010 (BUN indirect), mem[0x010]=16'h0123 -> reads at 0 then 0x010, no o_exec pulse, next fetch at 0x123.
- mem[0]=16'h7001 (HLT) -> o_halt=1, o_busy=0, no further requests. i_start -> fetch resumes at PC=1.
- EXEC with i_ex_done&i_skip at PC=5 -> next fetch at 6. Repeat with i_pc_load=1, i_pc_value=0x2A together with i_skip -> next fetch at 0x2A.
- i_irq=1, i_ien=1 during EXEC at PC=7, then i_ex_done -> write addr 0, wdata 16'h0007, o_int_ack pulse, next fetch at 1.
- Ack delayed 3 cycles -> req/addr held stable. PC=12'hFFF fetch -> PC wraps to 0. reset_n low during a pending read -> req drops immediately, state IDLE, PC=RESET_PC.
